store_block: RTL and testbench

Writes a Tn×Tn register block back into the single-port N×N matrix memory at `M[block_row:block_row+Tn-1, block_col:block_col+Tn-1]`. It is the write-side counterpart of the block loader and drains result tiles of the blocked matrix multiply. It runs in two modes:
- **Overwrite:** plain store of the tile.
- **Accumulate:** read-modify-write, `M += block`, for partial-sum tiles.

It shares the loader's memory port conventions: `addr = row*N + col` and 2-cycle read latency.

---
 rtl/mat_pkg.sv | 27 ++
 rtl/block_addr_gen.sv | 72 +++++++
 rtl/store_block.sv | 169 ++++++++++++++++
 tb/tb_store_block.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/mat_pkg.sv
// Shared constants, element type, store FSM states and tile address helper
// for the blocked matrix datapath.
package mat_pkg;

    localparam int Tn = 4;   // tile edge
    localparam int N  = 16;  // matrix edge / row stride
    localparam int DW = 16;  // element width
    localparam int AW = 8;   // memory address width

    typedef logic [DW-1:0] elem_t;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        DRAIN,
        WR,
        FIN
    } store_state_t;

    // Full-width linear address of matrix element (row, col); callers truncate.
    function automatic logic [31:0] tile_addr(input logic [31:0] row,
                                              input logic [31:0] col,
                                              input logic [31:0] stride);
        return row * stride + col;
    endfunction

endpackage

// File: rtl/block_addr_gen.sv
// Row-major (r,c) walker over a Tn x Tn tile with a registered memory
// address. clear restarts at (0,0); step advances; the address register
// only moves when the counter does, so it holds through idle/drain cycles.
module block_addr_gen #(
    parameter int Tn = mat_pkg::Tn,
    parameter int N  = mat_pkg::N,
    parameter int AW = mat_pkg::AW,
    localparam int CW = (Tn > 1) ? $clog2(Tn) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          step,
    input  logic [7:0]    base_row,
    input  logic [7:0]    base_col,
    output logic [CW-1:0] r,
    output logic [CW-1:0] c,
    output logic [CW-1:0] r_inc,
    output logic [CW-1:0] c_inc,
    output logic          last,
    output logic [AW-1:0] addr
);
    import mat_pkg::*;

    localparam logic [CW-1:0] LAST_IDX = CW'(Tn - 1);

    logic [CW-1:0] r_q, r_d, c_q, c_d;
    logic [AW-1:0] addr_q, addr_d;

    // Successor of the current index and next counter/address values.
    always_comb begin
        r_inc  = r_q;
        c_inc  = c_q + 1'b1;
        if (c_q == LAST_IDX) begin
            c_inc = '0;
            r_inc = r_q + 1'b1;
        end
        r_d    = r_q;
        c_d    = c_q;
        addr_d = addr_q;
        if (clear) begin
            r_d = '0;
            c_d = '0;
        end else if (step) begin
            r_d = r_inc;
            c_d = c_inc;
        end
        if (clear || step) begin
            addr_d = AW'(tile_addr(32'(base_row) + 32'(r_d),
                                   32'(base_col) + 32'(c_d), 32'(N)));
        end
    end

    // Counter and address registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_q    <= '0;
            c_q    <= '0;
            addr_q <= '0;
        end else begin
            r_q    <= r_d;
            c_q    <= c_d;
            addr_q <= addr_d;
        end
    end

    assign r    = r_q;
    assign c    = c_q;
    assign last = (r_q == LAST_IDX) && (c_q == LAST_IDX);
    assign addr = addr_q;

endmodule

// File: rtl/store_block.sv
// Writes a Tn x Tn tile back into the N x N matrix memory, either as a plain
// overwrite or as a read-modify-write accumulate (M += block). Outputs are
// registered from next-state values so the first access lands in the cycle
// right after start is sampled.
module store_block #(
    parameter int Tn = mat_pkg::Tn,
    parameter int N  = mat_pkg::N,
    parameter int DW = mat_pkg::DW,
    parameter int AW = mat_pkg::AW
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    input  logic                            accumulate,
    input  logic [7:0]                      block_row,
    input  logic [7:0]                      block_col,
    input  logic [0:Tn-1][0:Tn-1][DW-1:0]   block_mat,
    output logic [AW-1:0]                   addr,
    output logic [DW-1:0]                   dout,
    output logic                            we,
    input  logic [DW-1:0]                   din,
    output logic                            busy,
    output logic                            done
);
    import mat_pkg::*;

    localparam int CW = (Tn > 1) ? $clog2(Tn) : 1;

    store_state_t state_q, state_d;
    logic [7:0]   row_q, row_d, col_q, col_d;
    logic         drn_q, drn_d;
    logic         we_q, we_d;
    logic [DW-1:0] dout_q, dout_d;
    logic [0:Tn-1][0:Tn-1][DW-1:0] buf_q, buf_d;

    // Read-capture alignment: stage 1 holds the index whose din is on the bus.
    logic [1:0]          cap_vld_q, cap_vld_d;
    logic [1:0][CW-1:0]  cap_r_q, cap_r_d, cap_c_q, cap_c_d;

    logic          accept, clear, step, last;
    logic [CW-1:0] cnt_r, cnt_c, inc_r, inc_c;
    logic [7:0]    base_row, base_col;

    assign accept = start && ((state_q == IDLE) || (state_q == FIN));
    // The walker loads its first address on the accepting edge, before the
    // latched base is visible, so feed it the live inputs then.
    assign base_row = accept ? block_row : row_q;
    assign base_col = accept ? block_col : col_q;

    block_addr_gen #(.Tn(Tn), .N(N), .AW(AW)) u_addr (
        .clk      (clk),
        .rst      (rst),
        .clear    (clear),
        .step     (step),
        .base_row (base_row),
        .base_col (base_col),
        .r        (cnt_r),
        .c        (cnt_c),
        .r_inc    (inc_r),
        .c_inc    (inc_c),
        .last     (last),
        .addr     (addr)
    );

    // Tile buffer: snapshot on accept, accumulate returned reads (wrapping).
    always_comb begin
        buf_d     = buf_q;
        cap_vld_d = {cap_vld_q[0], state_q == RD};
        cap_r_d   = {cap_r_q[0], cnt_r};
        cap_c_d   = {cap_c_q[0], cnt_c};
        if (accept) begin
            buf_d = block_mat;
        end else if (cap_vld_q[1]) begin
            buf_d[cap_r_q[1]][cap_c_q[1]] = buf_q[cap_r_q[1]][cap_c_q[1]] + din;
        end
    end

    // Next state, walker control and registered write port values.
    // The mode bit is captured by the choice of RD vs WR on accept.
    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        drn_d   = drn_q;
        we_d    = 1'b0;
        dout_d  = dout_q;
        clear   = 1'b0;
        step    = 1'b0;
        case (state_q)
            IDLE, FIN: begin
                state_d = IDLE;
                if (accept) begin
                    row_d = block_row;
                    col_d = block_col;
                    drn_d = 1'b0;
                    clear = 1'b1;
                    if (accumulate) begin
                        state_d = RD;
                    end else begin
                        state_d = WR;
                        we_d    = 1'b1;
                        dout_d  = buf_d[0][0];
                    end
                end
            end
            RD: begin
                if (last) state_d = DRAIN;
                else      step    = 1'b1;
            end
            DRAIN: begin
                if (drn_q) begin
                    state_d = WR;
                    drn_d   = 1'b0;
                    clear   = 1'b1;
                    we_d    = 1'b1;
                    dout_d  = buf_d[0][0];
                end else begin
                    drn_d = 1'b1;
                end
            end
            WR: begin
                if (last) begin
                    state_d = FIN;
                end else begin
                    step   = 1'b1;
                    we_d   = 1'b1;
                    dout_d = buf_d[inc_r][inc_c];
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control and output registers; reset abandons any tile in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            row_q     <= '0;
            col_q     <= '0;
            drn_q     <= 1'b0;
            we_q      <= 1'b0;
            dout_q    <= '0;
            cap_vld_q <= '0;
            cap_r_q   <= '0;
            cap_c_q   <= '0;
        end else begin
            state_q   <= state_d;
            row_q     <= row_d;
            col_q     <= col_d;
            drn_q     <= drn_d;
            we_q      <= we_d;
            dout_q    <= dout_d;
            cap_vld_q <= cap_vld_d;
            cap_r_q   <= cap_r_d;
            cap_c_q   <= cap_c_d;
        end
    end

    // Tile data storage; contents are don't-care after reset.
    always_ff @(posedge clk) begin
        buf_q <= buf_d;
    end

    assign we   = we_q;
    assign dout = dout_q;
    assign busy = (state_q == RD) || (state_q == DRAIN) || (state_q == WR);
    assign done = (state_q == FIN);

endmodule

// File: tb/tb_store_block.sv
// Bench for store_block: a memory with 2-cycle read latency, a per-job
// reference computed from the memory contents at start, and cycle-exact
// checks of we/addr/dout/busy/done.
module tb_store_block;
    localparam int TN = 4;
    localparam int N  = 16;
    localparam int DW = 16;
    localparam int AW = 8;
    localparam int T2 = TN * TN;

    typedef logic [0:TN-1][0:TN-1][DW-1:0] blk_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          accumulate = 1'b0;
    logic [7:0]    block_row = '0;
    logic [7:0]    block_col = '0;
    blk_t          block_mat = '0;
    logic [AW-1:0] addr;
    logic [DW-1:0] dout;
    logic          we;
    logic [DW-1:0] din;
    logic          busy;
    logic          done;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] mem [256];
    logic [DW-1:0] rd_p1;
    int            fill_mode = 0;
    logic [DW-1:0] fill_val = '0;

    store_block dut (
        .clk(clk), .rst(rst), .start(start), .accumulate(accumulate),
        .block_row(block_row), .block_col(block_col), .block_mat(block_mat),
        .addr(addr), .dout(dout), .we(we), .din(din), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Memory: writes on we, reads return 2 cycles after the address.
    always @(posedge clk) begin
        if (fill_mode == 1) begin
            for (int i = 0; i < 256; i++) mem[i] <= fill_val;
        end else if (fill_mode == 2) begin
            for (int i = 0; i < 256; i++) mem[i] <= DW'($urandom);
        end else if (we) begin
            mem[addr] <= dout;
        end
        rd_p1 <= mem[addr];
        din   <= rd_p1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic fill(input int mode, input logic [DW-1:0] val);
        @(negedge clk);
        fill_mode = mode;
        fill_val  = val;
        @(negedge clk);
        fill_mode = 0;
    endtask

    // Starts a job at the current negedge and checks every cycle through done.
    // Inputs are perturbed after start; a start pulse is injected at cycle poke.
    task automatic run_job(input string nm, input bit acc, input int br, input int bc,
                           input blk_t blk, input int poke);
        int ea[T2];
        int ed[T2];
        int total, i, w;
        bit e_we, e_busy, e_done, c_addr, c_dout;
        start = 1'b1; accumulate = acc; block_row = 8'(br); block_col = 8'(bc);
        block_mat = blk;
        for (int r = 0; r < TN; r++) begin
            for (int c = 0; c < TN; c++) begin
                i = r * TN + c;
                ea[i] = ((br + r) * N + bc + c) % 256;
                ed[i] = acc ? (int'(mem[ea[i]]) + int'(blk[r][c])) % 65536 : int'(blk[r][c]);
            end
        end
        total = acc ? 2 * T2 + 3 : T2 + 1;
        @(posedge clk);
        @(negedge clk);
        for (int k = 1; k <= total; k++) begin
            start = (k == poke);
            block_row = 8'(br) ^ 8'h20;
            accumulate = ~acc;
            block_mat = ~blk;
            e_we = 0; e_busy = 1; e_done = 0; c_addr = 0; c_dout = 0; w = 0; i = 0;
            if (k == total) begin
                e_busy = 0; e_done = 1;
            end else if (!acc) begin
                e_we = 1; c_addr = 1; c_dout = 1; w = k - 1; i = k - 1;
            end else if (k <= T2) begin
                c_addr = 1; w = k - 1;
            end else if (k >= T2 + 3) begin
                e_we = 1; c_addr = 1; c_dout = 1; w = k - T2 - 3; i = w;
            end
            check($sformatf("%s c%0d we", nm, k), 32'(we), 32'(e_we));
            check($sformatf("%s c%0d busy", nm, k), 32'(busy), 32'(e_busy));
            check($sformatf("%s c%0d done", nm, k), 32'(done), 32'(e_done));
            if (c_addr) check($sformatf("%s c%0d addr", nm, k), 32'(addr), 32'(ea[w]));
            if (c_dout) check($sformatf("%s c%0d dout", nm, k), 32'(dout), 32'(ed[i]));
            if (k < total) begin
                @(posedge clk);
                @(negedge clk);
            end
        end
        start = 1'b0;
    endtask

    task automatic idle(input string nm, input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            @(negedge clk);
            check($sformatf("%s idle%0d we", nm, k), 32'(we), 32'd0);
            check($sformatf("%s idle%0d busy", nm, k), 32'(busy), 32'd0);
            check($sformatf("%s idle%0d done", nm, k), 32'(done), 32'd0);
        end
    endtask

    initial begin
        blk_t b;
        #2 rst = 1'b0;
        fill(1, 16'd0);
        check("rst we", 32'(we), 32'd0);
        check("rst addr", 32'(addr), 32'd0);
        check("rst dout", 32'(dout), 32'd0);
        check("rst busy", 32'(busy), 32'd0);
        check("rst done", 32'(done), 32'd0);
        rst = 1'b1;
        @(negedge clk);

        // Overwrite of tile (4,8) with 1..16.
        for (int r = 0; r < TN; r++)
            for (int c = 0; c < TN; c++) b[r][c] = DW'(r * 4 + c + 1);
        run_job("ovw", 1'b0, 4, 8, b, 0);
        idle("ovw", 2);

        // Accumulate onto 100s at tile (0,0).
        fill(1, 16'd100);
        run_job("acc", 1'b1, 0, 0, b, 0);
        idle("acc", 1);

        // Wrap-around of the modular add.
        fill(1, 16'hFFFF);
        for (int r = 0; r < TN; r++)
            for (int c = 0; c < TN; c++) b[r][c] = 16'd2;
        run_job("wrap", 1'b1, 0, 0, b, 0);
        check("wrap mem0", 32'(mem[0]), 32'h1);
        idle("wrap", 1);

        // start mid-job (cycle 5) is ignored; exactly one done follows.
        for (int r = 0; r < TN; r++)
            for (int c = 0; c < TN; c++) b[r][c] = DW'($urandom);
        run_job("ign", 1'b0, 4, 8, b, 5);
        idle("ign", 3);

        // Back-to-back jobs with start in the done cycle.
        fill(2, 16'd0);
        run_job("b2b0", 1'b0, 2, 3, b, 0);
        run_job("b2b1", 1'b1, 2, 3, ~b, 0);
        run_job("b2b2", 1'b0, 12, 12, b, 0);
        idle("b2b", 1);

        // Reset in cycle 8 of an accumulate clears outputs without a clock edge.
        for (int r = 0; r < TN; r++)
            for (int c = 0; c < TN; c++) b[r][c] = DW'(r * 4 + c + 1);
        start = 1'b1; accumulate = 1'b1; block_row = 8'd2; block_col = 8'd4;
        block_mat = b;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        for (int k = 1; k < 8; k++) begin
            @(posedge clk);
            @(negedge clk);
        end
        check("pre-rst busy", 32'(busy), 32'd1);
        rst = 1'b0;
        #1;
        check("mid-rst we", 32'(we), 32'd0);
        check("mid-rst addr", 32'(addr), 32'd0);
        check("mid-rst dout", 32'(dout), 32'd0);
        check("mid-rst busy", 32'(busy), 32'd0);
        check("mid-rst done", 32'(done), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        run_job("post-rst", 1'b0, 8, 0, b, 0);
        idle("post-rst", 1);

        // Randomized jobs over random memory, sometimes chained.
        fill(2, 16'd0);
        for (int j = 0; j < 20; j++) begin
            for (int r = 0; r < TN; r++)
                for (int c = 0; c < TN; c++) b[r][c] = DW'($urandom);
            run_job($sformatf("rnd%0d", j), 1'($urandom), int'($urandom_range(0, N - TN)),
                    int'($urandom_range(0, N - TN)), b, int'($urandom_range(0, 12)));
            idle($sformatf("rnd%0d", j), int'($urandom_range(0, 2)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
